mem_port_arbiter: RTL and testbench

//  Shares one single-port program/data memory between the pipeline's instruction-fetch port
//  (pc_address) and its data port (data_address/memread/memwrite). Arbitrates, issues one

---
 rtl/mem_port_arbiter_if.sv | 38 +++
 rtl/mem_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the unified memory.
// The slave modport is the arbiter's view; master is the surrounding pipeline and memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data ports, one access at a time.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration instead of D-priority with IF starvation guard.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2,
  parameter int STARVE_MAX  = 4
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus,
  output logic              busy
);
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              win_d_q, win_d_d;
  logic              is_wr_q, is_wr_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_gnt_q, if_gnt_d;
  logic              d_gnt_q, d_gnt_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              pick_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // last_win_q: 1 when the data port won the previous grant
  logic last_win_q, last_win_d;

  assign pick_d = bus.d_req & (~bus.if_req | ~last_win_q);
`else
  logic [3:0] starve_q, starve_d;
  logic       both_req;

  assign both_req = bus.if_req & bus.d_req;
  assign pick_d   = bus.d_req & (~bus.if_req | (starve_q != 4'(STARVE_MAX)));
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    win_d_d     = win_d_q;
    is_wr_d     = is_wr_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_win_d  = last_win_q;
`else
    starve_d    = starve_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        // Grant and memory strobe are registered, so they appear in the ACCESS cycle
        if (bus.if_req | bus.d_req) begin
          state_d     = S_ACCESS;
          win_d_d     = pick_d;
          is_wr_d     = pick_d & bus.d_we;
          mem_en_d    = 1'b1;
          mem_we_d    = pick_d & bus.d_we;
          mem_addr_d  = pick_d ? bus.d_addr : bus.if_addr;
          mem_wdata_d = pick_d ? bus.d_wdata : '0;
          if_gnt_d    = ~pick_d;
          d_gnt_d     = pick_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_win_d  = pick_d;
`else
          if (!pick_d) begin
            starve_d = '0;
          end else if (both_req && starve_q != 4'hF) begin
            starve_d = starve_q + 4'd1;
          end
`endif
        end
      end
      S_ACCESS: begin
        cnt_d   = 4'(MEM_LATENCY - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d     = S_RESP;
          d_rvalid_d  = win_d_q;
          if_rvalid_d = ~win_d_q;
          if (!is_wr_q) begin
            if (win_d_q) begin
              d_rdata_d = bus.mem_rdata;
            end else begin
              if_rdata_d = bus.mem_rdata;
            end
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      win_d_q     <= 1'b0;
      is_wr_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_win_q  <= 1'b0;
`else
      starve_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      win_d_q     <= win_d_d;
      is_wr_q     <= is_wr_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_win_q  <= last_win_d;
`else
      starve_q    <= starve_d;
`endif
    end
  end

  assign bus.if_gnt    = if_gnt_q;
  assign bus.d_gnt     = d_gnt_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign busy          = (state_q != S_IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a transaction-level model predicts every output each cycle.
// Honours MEM_ARB_ROUND_ROBIN_EN the same way as the design.
module tb_mem_port_arbiter;
  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int MEM_LATENCY = 2;
  localparam int STARVE_MAX  = 4;

  logic clk = 1'b0;
  logic reset;
  logic busy;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LATENCY(MEM_LATENCY), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: at most one transaction in flight, granted in cycle tx_g
  bit          tx_valid;
  bit          tx_is_d;
  bit          tx_we;
  logic [31:0] tx_addr;
  logic [31:0] tx_wdata;
  int          tx_g;
  int          next_sample;
  logic [31:0] exp_if_rdata;
  logic [31:0] exp_d_rdata;
  logic [31:0] model_mem [logic [31:0]];
`ifdef MEM_ARB_ROUND_ROBIN_EN
  bit          last_d;
`else
  int          if_losses;
`endif

  // Memory environment, fed only by what the DUT actually puts on the bus
  logic [31:0] env_mem [logic [31:0]];
  int          due_q[$];
  logic [31:0] data_q[$];

  bit          rand_en, hold_if, hold_d, log_en;
  bit          pend_if, pend_d, pend_d_we;
  logic [31:0] pend_if_addr, pend_d_addr, pend_d_wdata;
  bit          win_log[$];
  int          if_gnt_cyc, d_gnt_cyc, if_rv_cyc, d_rv_cyc;

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h0050_0113;
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] env_read(input logic [31:0] a);
    return env_mem.exists(a) ? env_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] rand_d_addr();
    return 32'h1001_0000 + 32'($urandom_range(15)) * 32'd4;
  endfunction

  task automatic apply_stimulus();
    if (bus.if_gnt) begin
      if (hold_if) bus.if_addr = 32'h0040_0000 + 32'($urandom_range(63)) * 32'd4;
      else bus.if_req = 1'b0;
    end
    if (bus.d_gnt) begin
      if (hold_d) begin
        bus.d_we   = 1'b0;
        bus.d_addr = rand_d_addr();
      end else begin
        bus.d_req = 1'b0;
      end
    end
    if (pend_if && !bus.if_req) begin
      bus.if_req  = 1'b1;
      bus.if_addr = pend_if_addr;
      pend_if     = 1'b0;
    end
    if (pend_d && !bus.d_req) begin
      bus.d_req   = 1'b1;
      bus.d_we    = pend_d_we;
      bus.d_addr  = pend_d_addr;
      bus.d_wdata = pend_d_wdata;
      pend_d      = 1'b0;
    end
    if (rand_en && !bus.if_req && $urandom_range(2) == 0) begin
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h0040_0000 + 32'($urandom_range(63)) * 32'd4;
    end
    if (rand_en && !bus.d_req && $urandom_range(2) == 0) begin
      bus.d_req   = 1'b1;
      bus.d_we    = 1'($urandom_range(1));
      bus.d_addr  = rand_d_addr();
      bus.d_wdata = $urandom;
    end
  endtask

  task automatic model_decide();
    bit pick_d;
    bit both;
    both = bus.if_req && bus.d_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    pick_d = both ? !last_d : bus.d_req;
    last_d = pick_d;
`else
    if (both) begin
      if (if_losses == STARVE_MAX) begin
        pick_d    = 1'b0;
        if_losses = 0;
      end else begin
        pick_d = 1'b1;
        if_losses++;
      end
    end else begin
      pick_d = bus.d_req;
      if (!pick_d) if_losses = 0;
    end
`endif
    tx_valid = 1'b1;
    tx_is_d  = pick_d;
    tx_g     = cyc + 1;
    tx_we    = pick_d && bus.d_we;
    tx_addr  = pick_d ? bus.d_addr : bus.if_addr;
    tx_wdata = bus.d_wdata;
  endtask

  // One clock: check the model's prediction, play memory, drive requesters, arbitrate in the model
  task automatic step_cycle();
    bit active;
    @(posedge clk);
    #1;
    cyc++;
    active = tx_valid;
    if (active && cyc == tx_g + MEM_LATENCY + 1 && !tx_we) begin
      if (tx_is_d) exp_d_rdata = model_read(tx_addr);
      else exp_if_rdata = model_read(tx_addr);
    end
    check_output("if_gnt", bus.if_gnt, active && cyc == tx_g && !tx_is_d);
    check_output("d_gnt", bus.d_gnt, active && cyc == tx_g && tx_is_d);
    check_output("mem_en", bus.mem_en, active && cyc == tx_g);
    check_output("mem_we", bus.mem_we, active && cyc == tx_g && tx_we);
    check_output("busy", busy, active && cyc >= tx_g && cyc <= tx_g + MEM_LATENCY + 1);
    check_output("if_rvalid", bus.if_rvalid, active && !tx_is_d && cyc == tx_g + MEM_LATENCY + 1);
    check_output("d_rvalid", bus.d_rvalid, active && tx_is_d && cyc == tx_g + MEM_LATENCY + 1);
    check_output("if_rdata", bus.if_rdata, exp_if_rdata);
    check_output("d_rdata", bus.d_rdata, exp_d_rdata);
    if (active && cyc == tx_g) begin
      check_output("mem_addr", bus.mem_addr, tx_addr);
      if (tx_we) begin
        check_output("mem_wdata", bus.mem_wdata, tx_wdata);
        model_mem[tx_addr] = tx_wdata;
      end
    end

    if (bus.if_gnt) begin
      if_gnt_cyc = cyc;
      if (log_en) win_log.push_back(1'b0);
    end
    if (bus.d_gnt) begin
      d_gnt_cyc = cyc;
      if (log_en) win_log.push_back(1'b1);
    end
    if (bus.if_rvalid) if_rv_cyc = cyc;
    if (bus.d_rvalid) d_rv_cyc = cyc;

    if (bus.mem_en) begin
      if (bus.mem_we) begin
        env_mem[bus.mem_addr] = bus.mem_wdata;
      end else begin
        due_q.push_back(cyc + MEM_LATENCY);
        data_q.push_back(env_read(bus.mem_addr));
      end
    end
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      void'(due_q.pop_front());
      bus.mem_rdata = data_q.pop_front();
    end else begin
      bus.mem_rdata = $urandom;
    end

    apply_stimulus();

    if (cyc == next_sample) begin
      if (bus.if_req || bus.d_req) begin
        model_decide();
        next_sample = cyc + 3 + MEM_LATENCY;
      end else begin
        next_sample = cyc + 1;
      end
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) step_cycle();
  endtask

  task automatic apply_reset();
    reset       = 1'b1;
    bus.if_req  = 1'b0;
    bus.d_req   = 1'b0;
    pend_if     = 1'b0;
    pend_d      = 1'b0;
    tx_valid    = 1'b0;
    exp_if_rdata = '0;
    exp_d_rdata  = '0;
    due_q.delete();
    data_q.delete();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_d = 1'b0;
`else
    if_losses = 0;
`endif
    #1;
    check_output("rst_busy", busy, 1'b0);
    check_output("rst_gnt", {bus.if_gnt, bus.d_gnt}, 2'b00);
    check_output("rst_rvalid", {bus.if_rvalid, bus.d_rvalid}, 2'b00);
    check_output("rst_mem_ctl", {bus.mem_en, bus.mem_we}, 2'b00);
    check_output("rst_mem_addr", bus.mem_addr, 32'h0);
    check_output("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check_output("rst_rdata", {bus.if_rdata, bus.d_rdata}, 64'h0);
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    reset       = 1'b0;
    next_sample = cyc + 1;
  endtask

  initial begin
    int waited;
    bit exp_win;
    reset         = 1'b0;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_rdata = '0;
    rand_en = 1'b0;
    hold_if = 1'b0;
    hold_d  = 1'b0;
    log_en  = 1'b0;
    apply_reset();

    // Single fetch: gnt one cycle after sampling, data three cycles after gnt
    pend_if      = 1'b1;
    pend_if_addr = 32'h0040_0000;
    run_cycles(8);
    check_output("t1_latency", if_rv_cyc - if_gnt_cyc, 3);
    check_output("t1_rdata", bus.if_rdata, 32'h0050_0113);

    // Simultaneous fetch and load: D first, IF at the next IDLE sample
    pend_if      = 1'b1;
    pend_if_addr = 32'h0040_0004;
    pend_d       = 1'b1;
    pend_d_we    = 1'b0;
    pend_d_addr  = 32'h1001_0004;
    pend_d_wdata = '0;
    run_cycles(14);
    check_output("t2_gnt_gap", if_gnt_cyc - d_gnt_cyc, 5);
    check_output("t2_d_rdata", bus.d_rdata, init_word(32'h1001_0004));

    // Store: d_rdata must keep the previous load value
    pend_d       = 1'b1;
    pend_d_we    = 1'b1;
    pend_d_addr  = 32'h1001_0000;
    pend_d_wdata = 32'hDEAD_BEEF;
    run_cycles(8);
    check_output("t4_ack_latency", d_rv_cyc - d_gnt_cyc, 3);

    // Both requesters held high from reset: check the grant order
    apply_reset();
    win_log.delete();
    log_en       = 1'b1;
    hold_if      = 1'b1;
    hold_d       = 1'b1;
    pend_if      = 1'b1;
    pend_if_addr = 32'h0040_0100;
    pend_d       = 1'b1;
    pend_d_we    = 1'b0;
    pend_d_addr  = 32'h1001_0008;
    run_cycles(10 * (3 + MEM_LATENCY) + 2);
    hold_if = 1'b0;
    hold_d  = 1'b0;
    log_en  = 1'b0;
    run_cycles(15);
    check_output("t3_grant_count_ge10", win_log.size() >= 10, 1'b1);
    for (int i = 0; i < 10 && i < win_log.size(); i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_win = (i % 2 == 0);
`else
      exp_win = (i % (STARVE_MAX + 1) != STARVE_MAX);
`endif
      check_output($sformatf("t3_grant_%0d_is_d", i), win_log[i], exp_win);
    end

    // Random traffic
    apply_reset();
    rand_en = 1'b1;
    run_cycles(1500);
    rand_en = 1'b0;
    run_cycles(30);

    // Reset while the access is waiting on memory
    pend_d       = 1'b1;
    pend_d_we    = 1'b0;
    pend_d_addr  = 32'h1001_000C;
    waited = 0;
    while (!(tx_valid && cyc == tx_g + 1) && waited < 20) begin
      step_cycle();
      waited++;
    end
    check_output("t5_reached_wait", waited < 20, 1'b1);
    apply_reset();
    d_rv_cyc = -1;
    run_cycles(10);
    check_output("t5_no_rvalid", d_rv_cyc, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
